// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the priority interrupt controller: widths, register
// offsets, FSM encoding, source bit positions and a one-hot helper.
package irq_ctrl_pkg;

    localparam int CPU_WIDTH = 16;
    localparam int IRQ_NUM   = 8;
    localparam int ID_W      = 3;

    typedef enum logic [1:0] {
        IRQ_CTRL = 2'd0,
        IRQ_EN   = 2'd1,
        IRQ_PEND = 2'd2,
        IRQ_STAT = 2'd3
    } irq_reg_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_e;

    typedef enum int {
        SRC_TIMER   = 0,
        SRC_UART    = 1,
        SRC_BUTTONS = 2
    } irq_src_e;

    function automatic logic [IRQ_NUM-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [IRQ_NUM-1:0] one_s;
        one_s = {{(IRQ_NUM-1){1'b0}}, 1'b1};
        return one_s << id;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus and CPU request/acknowledge handshake of the interrupt controller.
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic                 reg_sel;
    logic [1:0]           reg_addr;
    logic                 reg_we;
    logic [CPU_WIDTH-1:0] reg_wd;
    logic [CPU_WIDTH-1:0] reg_rd;
    logic                 irq_req;
    logic [ID_W-1:0]      irq_id;
    logic                 irq_ack;
    logic                 irq_eoi;

    modport master (
        output reg_sel, reg_addr, reg_we, reg_wd, irq_ack, irq_eoi,
        input  reg_rd, irq_req, irq_id
    );

    modport slave (
        input  reg_sel, reg_addr, reg_we, reg_wd, irq_ack, irq_eoi,
        output reg_rd, irq_req, irq_id
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: valid when any bit is set, id of the
// lowest set bit (index 0 is the highest priority).
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [IRQ_NUM-1:0] vec,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan from the top down so the lowest set index is the one that sticks.
    always_comb begin
        valid = |vec;
        id    = {ID_W{1'b0}};
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            id = vec[i] ? ID_W'(i) : id;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Priority interrupt controller: edge-detects sources, latches pending bits,
// masks, and hands one vector ID to the CPU. Define IRQ_NEST_EN for nesting.
module irq_ctrl
    import irq_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IRQ_NUM-1:0] irq,
    irq_ctrl_if.slave          bus
);

    logic                 gie_r;
    logic [IRQ_NUM-1:0]   en_r;
    logic [IRQ_NUM-1:0]   pend_r;
    logic [IRQ_NUM-1:0]   isr_r;
    logic [IRQ_NUM-1:0]   irq_prev_r;
    irq_state_e           state_r;
    logic                 irq_req_r;
    logic [ID_W-1:0]      irq_id_r;

    logic                 wr_s;
    logic                 gie_nxt_s;
    logic [IRQ_NUM-1:0]   en_nxt_s;
    logic [IRQ_NUM-1:0]   w1c_s;
    logic [IRQ_NUM-1:0]   rise_s;
    logic                 ack_s;
    logic [IRQ_NUM-1:0]   ack_mask_s;
    logic [IRQ_NUM-1:0]   pend_nxt_s;
    logic [IRQ_NUM-1:0]   isr_eoi_s;
    logic [IRQ_NUM-1:0]   isr_nxt_s;
    logic                 cand_valid_s;
    logic [ID_W-1:0]      cand_id_s;
    logic                 isr_valid_s;
    logic [ID_W-1:0]      isr_id_s;
    logic                 eligible_s;
    logic                 withdraw_s;
    logic [CPU_WIDTH-1:0] rd_s;
    logic                 wd_unused_s;

    assign wd_unused_s = ^bus.reg_wd[CPU_WIDTH-1:IRQ_NUM];

    irq_prio_enc u_cand_enc (
        .vec   (pend_r & en_r),
        .valid (cand_valid_s),
        .id    (cand_id_s)
    );

    irq_prio_enc u_isr_enc (
        .vec   (isr_r),
        .valid (isr_valid_s),
        .id    (isr_id_s)
    );

    assign wr_s       = bus.reg_sel & bus.reg_we;
    assign rise_s     = irq & ~irq_prev_r;
    assign ack_s      = (state_r == ST_REQ) & bus.irq_ack;
    assign ack_mask_s = ack_s ? id_onehot(irq_id_r) : {IRQ_NUM{1'b0}};

    // Register write decode; PEND writes produce a write-one-to-clear mask.
    always_comb begin
        gie_nxt_s = gie_r;
        en_nxt_s  = en_r;
        w1c_s     = {IRQ_NUM{1'b0}};
        if (wr_s) begin
            case (bus.reg_addr)
                IRQ_CTRL: gie_nxt_s = bus.reg_wd[0];
                IRQ_EN:   en_nxt_s  = bus.reg_wd[IRQ_NUM-1:0];
                IRQ_PEND: w1c_s     = bus.reg_wd[IRQ_NUM-1:0];
                default:  w1c_s     = {IRQ_NUM{1'b0}};
            endcase
        end else begin
            w1c_s = {IRQ_NUM{1'b0}};
        end
    end

    // A fresh rising edge always beats a software clear or an ack on the same bit.
    assign pend_nxt_s = (pend_r & ~w1c_s & ~ack_mask_s) | rise_s;

`ifdef IRQ_NEST_EN
    // End-of-interrupt retires only the highest-priority level in service.
    always_comb begin
        if (bus.irq_eoi && isr_valid_s) begin
            isr_eoi_s = isr_r & ~id_onehot(isr_id_s);
        end else begin
            isr_eoi_s = isr_r;
        end
    end

    assign eligible_s = gie_r & cand_valid_s & (~isr_valid_s | (cand_id_s < isr_id_s));
`else
    logic isr_id_unused_s;
    assign isr_id_unused_s = ^isr_id_s;

    // Without nesting at most one level is in service, so eoi empties ISR.
    always_comb begin
        if (bus.irq_eoi) begin
            isr_eoi_s = {IRQ_NUM{1'b0}};
        end else begin
            isr_eoi_s = isr_r;
        end
    end

    assign eligible_s = gie_r & cand_valid_s & ~isr_valid_s;
`endif

    // Ack lands after eoi so a same-cycle eoi cannot erase the new level.
    assign isr_nxt_s  = isr_eoi_s | ack_mask_s;
    assign withdraw_s = ~gie_nxt_s | ~pend_nxt_s[irq_id_r];

    // Configuration, pending, in-service and edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gie_r      <= 1'b0;
            en_r       <= {IRQ_NUM{1'b0}};
            pend_r     <= {IRQ_NUM{1'b0}};
            isr_r      <= {IRQ_NUM{1'b0}};
            irq_prev_r <= {IRQ_NUM{1'b0}};
        end else begin
            gie_r      <= gie_nxt_s;
            en_r       <= en_nxt_s;
            pend_r     <= pend_nxt_s;
            isr_r      <= isr_nxt_s;
            irq_prev_r <= irq;
        end
    end

    // Request FSM; irq_id is latched on entry to REQ and held until the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            irq_req_r <= 1'b0;
            irq_id_r  <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (eligible_s) begin
                        state_r   <= ST_REQ;
                        irq_req_r <= 1'b1;
                        irq_id_r  <= cand_id_s;
                    end else begin
                        irq_req_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bus.irq_ack || withdraw_s) begin
                        state_r   <= ST_IDLE;
                        irq_req_r <= 1'b0;
                    end else begin
                        irq_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    irq_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Read mux; unselected reads and unused bits return zero.
    always_comb begin
        rd_s = {CPU_WIDTH{1'b0}};
        if (bus.reg_sel) begin
            case (bus.reg_addr)
                IRQ_CTRL: rd_s[0]             = gie_r;
                IRQ_EN:   rd_s[IRQ_NUM-1:0]   = en_r;
                IRQ_PEND: rd_s[IRQ_NUM-1:0]   = pend_r;
                IRQ_STAT: begin
                    rd_s[IRQ_NUM-1:0]         = isr_r;
                    rd_s[IRQ_NUM+ID_W-1:IRQ_NUM] = irq_id_r;
                    rd_s[CPU_WIDTH-1]         = irq_req_r;
                end
                default:  rd_s                = {CPU_WIDTH{1'b0}};
            endcase
        end else begin
            rd_s = {CPU_WIDTH{1'b0}};
        end
    end

    assign bus.reg_rd  = rd_s;
    assign bus.irq_req = irq_req_r;
    assign bus.irq_id  = irq_id_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Table-driven bench for irq_ctrl: each vector drives one cycle of inputs, then
// checks irq_req, irq_id and a register read-back after the clock edge.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

`ifdef IRQ_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    typedef struct {
        logic [7:0]  irq;
        logic        we;
        logic [1:0]  waddr;
        logic [15:0] wd;
        logic        ack;
        logic        eoi;
        logic [1:0]  raddr;
        logic        exp_req;
        logic [2:0]  exp_id;
        logic [15:0] exp_rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq = 8'h00;
    int         checks = 0;
    int         errors = 0;
    vec_t       va[40];
    vec_t       vb[13];

    irq_ctrl_if bus();

    irq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irq   (irq),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] i, input logic we, input logic [1:0] wa,
                                input logic [15:0] wd, input logic ack, input logic eoi,
                                input logic [1:0] ra, input logic rq, input logic [2:0] id,
                                input logic [15:0] rd);
        vec_t v;
        v.irq = i; v.we = we; v.waddr = wa; v.wd = wd; v.ack = ack; v.eoi = eoi;
        v.raddr = ra; v.exp_req = rq; v.exp_id = id; v.exp_rd = rd;
        return v;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        irq          = v.irq;
        bus.reg_sel  = v.we;
        bus.reg_addr = v.waddr;
        bus.reg_we   = v.we;
        bus.reg_wd   = v.wd;
        bus.irq_ack  = v.ack;
        bus.irq_eoi  = v.eoi;
        @(posedge clk);
        #1;
        bus.reg_we   = 1'b0;
        bus.reg_wd   = 16'h0000;
        bus.irq_ack  = 1'b0;
        bus.irq_eoi  = 1'b0;
        bus.reg_sel  = 1'b1;
        bus.reg_addr = v.raddr;
        #1;
        check16({tag, " req"}, {15'h0000, bus.irq_req}, {15'h0000, v.exp_req});
        check16({tag, " id"},  {13'h0000, bus.irq_id},  {13'h0000, v.exp_id});
        check16({tag, " rd"},  bus.reg_rd, v.exp_rd);
    endtask

    initial begin
        //           irq    we    wa     wd        ack   eoi   ra     req  id    rd
        va[0]  = mk(8'h00, 1'b1, 2'd0, 16'h0001, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0001);
        va[1]  = mk(8'h00, 1'b1, 2'd1, 16'h0007, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 16'h0007);
        va[2]  = mk(8'h02, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0002);
        va[3]  = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd1, 16'h8100);
        va[4]  = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd1, 16'h8100);
        va[5]  = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 2'd3, 1'b0, 3'd1, 16'h0102);
        va[6]  = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd1, 16'h0000);
        va[7]  = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd3, 1'b0, 3'd1, 16'h0100);
        va[8]  = mk(8'h00, 1'b1, 2'd1, 16'h00FF, 1'b0, 1'b0, 2'd1, 1'b0, 3'd1, 16'h00FF);
        va[9]  = mk(8'h05, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd1, 16'h0005);
        va[10] = mk(8'h05, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd0, 16'h8000);
        va[11] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 2'd3, 1'b0, 3'd0, 16'h0001);
        va[12] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0004);
        va[13] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b0, 3'd0, 16'h0001);
        va[14] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd3, 1'b0, 3'd0, 16'h0000);
        va[15] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd2, 16'h8200);
        va[16] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 2'd3, 1'b0, 3'd2, 16'h0204);
        va[17] = mk(8'h01, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd2, 16'h0001);
        va[18] = mk(8'h01, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, NEST,
                    NEST ? 3'd0 : 3'd2, NEST ? 16'h8004 : 16'h0204);
        va[19] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 2'd3, 1'b0,
                    NEST ? 3'd0 : 3'd2, NEST ? 16'h0005 : 16'h0204);
        va[20] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd3, 1'b0,
                    NEST ? 3'd0 : 3'd2, NEST ? 16'h0004 : 16'h0200);
        va[21] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, !NEST,
                    3'd0, NEST ? 16'h0004 : 16'h8000);
        va[22] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 2'd3, 1'b0,
                    3'd0, NEST ? 16'h0000 : 16'h0001);
        va[23] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0, 16'h0000);
        va[24] = mk(8'h00, 1'b1, 2'd1, 16'h0000, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 16'h0000);
        va[25] = mk(8'h02, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0002);
        va[26] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b0, 3'd0, 16'h0000);
        va[27] = mk(8'h00, 1'b1, 2'd1, 16'h0002, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 16'h0002);
        va[28] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd1, 16'h8100);
        va[29] = mk(8'h00, 1'b1, 2'd2, 16'h0002, 1'b0, 1'b0, 2'd2, 1'b0, 3'd1, 16'h0000);
        va[30] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b0, 3'd1, 16'h0100);
        va[31] = mk(8'h00, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 16'h0000);
        va[32] = mk(8'h01, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd1, 16'h0001);
        va[33] = mk(8'h00, 1'b1, 2'd1, 16'h0001, 1'b0, 1'b0, 2'd1, 1'b0, 3'd1, 16'h0001);
        va[34] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b0, 3'd1, 16'h0100);
        va[35] = mk(8'h00, 1'b1, 2'd0, 16'h0001, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1, 16'h0001);
        va[36] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd0, 16'h8000);
        va[37] = mk(8'h00, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b0, 3'd0, 16'h0000);
        va[38] = mk(8'h00, 1'b1, 2'd0, 16'h0001, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0001);
        va[39] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd0, 16'h8000);

        vb[0]  = mk(8'h01, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0001);
        vb[1]  = mk(8'h01, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0001);
        vb[2]  = mk(8'h01, 1'b1, 2'd2, 16'h0001, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0000);
        vb[3]  = mk(8'h01, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0000);
        vb[4]  = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0000);
        vb[5]  = mk(8'h01, 1'b1, 2'd2, 16'h0001, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0001);
        vb[6]  = mk(8'h01, 1'b1, 2'd0, 16'h0001, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0001);
        vb[7]  = mk(8'h01, 1'b1, 2'd1, 16'h0001, 1'b0, 1'b0, 2'd1, 1'b0, 3'd0, 16'h0001);
        vb[8]  = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd0, 16'h8000);
        vb[9]  = mk(8'h01, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 2'd2, 1'b0, 3'd0, 16'h0001);
        vb[10] = mk(8'h01, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b0, 3'd0, 16'h0001);
        vb[11] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd3, 1'b0, 3'd0, 16'h0000);
        vb[12] = mk(8'h00, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b1, 3'd0, 16'h8000);

        bus.reg_sel  = 1'b0;
        bus.reg_addr = 2'd0;
        bus.reg_we   = 1'b0;
        bus.reg_wd   = 16'h0000;
        bus.irq_ack  = 1'b0;
        bus.irq_eoi  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check16("reset req", {15'h0000, bus.irq_req}, 16'h0000);
        check16("reset id", {13'h0000, bus.irq_id}, 16'h0000);
        check16("reset rd unselected", bus.reg_rd, 16'h0000);
        bus.reg_sel  = 1'b1;
        bus.reg_addr = 2'd3;
        #1;
        check16("reset stat", bus.reg_rd, 16'h0000);
        @(negedge clk);
        bus.reg_sel = 1'b0;
        rst_n       = 1'b1;

        for (int i = 0; i < 40; i++) begin
            apply(va[i], $sformatf("A%0d", i));
        end

        // Asynchronous reset while a request is outstanding.
        @(negedge clk);
        bus.reg_sel = 1'b0;
        #1;
        check16("rd unselected", bus.reg_rd, 16'h0000);
        bus.reg_sel  = 1'b1;
        bus.reg_addr = 2'd3;
        #1;
        check16("stat before reset", bus.reg_rd, 16'h8000);
        rst_n = 1'b0;
        #1;
        check16("midreq reset req", {15'h0000, bus.irq_req}, 16'h0000);
        check16("midreq reset id", {13'h0000, bus.irq_id}, 16'h0000);
        for (int a = 0; a < 4; a++) begin
            bus.reg_addr = 2'(a);
            #1;
            check16($sformatf("midreq reset reg%0d", a), bus.reg_rd, 16'h0000);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.reg_sel = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(vb[i], $sformatf("B%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
